// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared state encoding and width constants for pipeline stages.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        SKIDDED = 2'd2
    } pipe_state_e;

    localparam int OCC_W    = 2;

    // Typical payload widths for the classic five-stage boundaries
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 128;
    localparam int EX_MEM_W = 96;
    localparam int MEM_WB_W = 80;

endpackage

`default_nettype wire

// File: rtl/pipe_data_reg.sv
// ============================================================================
// Module : pipe_data_reg
// Brief  : Payload register with async reset, sync clear and load enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_data_reg #(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Clear outranks load so a flush always leaves the bubble behind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (clear) begin
            q <= BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module : pipe_stage_reg
// Brief  : Elastic pipeline-stage register with optional two-entry skid.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 64,
    parameter int                SKID   = 1,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [OCC_W-1:0]  occupancy
);

    pipe_state_e       r_state;
    logic              w_out_valid;
    logic              w_skid_valid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_normal;
    logic              w_main_load;
    logic              w_main_clear;
    logic [DATA_W-1:0] w_main_d;
    logic [DATA_W-1:0] w_skid_data;

    assign w_out_valid  = (r_state != EMPTY);
    assign w_skid_valid = (r_state == SKIDDED);
    assign w_in_fire    = in_valid & in_ready;
    assign w_out_fire   = w_out_valid & out_ready & ~freeze;
    assign w_normal     = ~flush & ~freeze;

    assign out_valid = w_out_valid;
    assign occupancy = {w_skid_valid & w_out_valid, w_out_valid ^ w_skid_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else if (flush) begin
            r_state <= EMPTY;
        end else if (!freeze) begin
            case (r_state)
                EMPTY:   if (w_in_fire) r_state <= FULL;
                FULL: begin
                    if (w_out_fire && !w_in_fire) begin
                        r_state <= EMPTY;
                    end else if (w_in_fire && !w_out_fire && (SKID != 0)) begin
                        r_state <= SKIDDED;
                    end
                end
                SKIDDED: if (w_out_fire) r_state <= FULL;
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign w_main_load  = w_normal & (((r_state == EMPTY) & w_in_fire) |
                                      ((r_state == FULL) & w_in_fire & w_out_fire) |
                                      ((r_state == SKIDDED) & w_out_fire));
    assign w_main_clear = flush | (w_normal & (r_state == FULL) & w_out_fire & ~w_in_fire);
    assign w_main_d     = (r_state == SKIDDED) ? w_skid_data : in_data;

    pipe_data_reg #(
        .DATA_W (DATA_W),
        .BUBBLE (BUBBLE)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .clear (w_main_clear),
        .load  (w_main_load),
        .d     (w_main_d),
        .q     (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic w_skid_load;
            logic w_skid_clear;

            // Registered ready: only the skid slot's occupancy gates intake
            assign in_ready     = ~freeze & ~w_skid_valid;
            assign w_skid_load  = w_normal & (r_state == FULL) & w_in_fire & ~w_out_fire;
            assign w_skid_clear = flush | (w_normal & (r_state == SKIDDED) & w_out_fire);

            pipe_data_reg #(
                .DATA_W (DATA_W),
                .BUBBLE (BUBBLE)
            ) u_skid (
                .clk   (clk),
                .rst   (rst),
                .clear (w_skid_clear),
                .load  (w_skid_load),
                .d     (in_data),
                .q     (w_skid_data)
            );
        end else begin : g_no_skid
            assign in_ready    = ~freeze & (~w_out_valid | out_ready);
            assign w_skid_data = BUBBLE;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances on shared stimulus.
`default_nettype none

module tb_pipe_stage_reg;

    localparam logic [15:0] BUB = 16'hBEEF;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, in_valid, out_ready;
    logic [15:0] in_data;

    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [15:0] out_data1, out_data0;
    logic [1:0]  occ1, occ0;

    int checks = 0;
    int errors = 0;

    logic [15:0] q1[$];
    logic [15:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(16), .SKID(1), .BUBBLE(BUB)) dut1 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
        .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(16), .SKID(0), .BUBBLE(BUB)) dut0 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready),
        .occupancy(occ0)
    );

    typedef struct packed {
        logic        fr;
        logic        fl;
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [15:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t tbl [0:26];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fr, input logic fl, input logic iv,
                         input logic [15:0] d, input logic ordy);
        freeze = fr; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    endtask

    // Reference: a FIFO of capacity 2 (skid) or 1, with ready derived from space
    function automatic logic m_ready(input int sz, input bit skid);
        if (freeze) return 1'b0;
        if (skid) return sz < 2;
        return (sz == 0) || out_ready;
    endfunction

    task automatic check_model(input bit with_skid1);
        chk("m0_in_ready", {31'd0, in_ready0}, {31'd0, m_ready(q0.size(), 1'b0)});
        chk("m0_out_valid", {31'd0, out_valid0}, {31'd0, q0.size() > 0});
        chk("m0_out_data", {16'd0, out_data0}, {16'd0, (q0.size() > 0) ? q0[0] : BUB});
        chk("m0_occupancy", {30'd0, occ0}, q0.size());
        if (with_skid1) begin
            chk("m1_in_ready", {31'd0, in_ready1}, {31'd0, m_ready(q1.size(), 1'b1)});
            chk("m1_out_valid", {31'd0, out_valid1}, {31'd0, q1.size() > 0});
            chk("m1_out_data", {16'd0, out_data1}, {16'd0, (q1.size() > 0) ? q1[0] : BUB});
            chk("m1_occupancy", {30'd0, occ1}, q1.size());
        end
    endtask

    task automatic advance();
        bit rdy1, rdy0, of1, of0;
        @(posedge clk);
        rdy1 = m_ready(q1.size(), 1'b1);
        rdy0 = m_ready(q0.size(), 1'b0);
        of1  = (q1.size() > 0) && out_ready && !freeze;
        of0  = (q0.size() > 0) && out_ready && !freeze;
        if (flush) begin
            q1.delete();
            q0.delete();
        end else if (!freeze) begin
            if (of1) void'(q1.pop_front());
            if (in_valid && rdy1) q1.push_back(in_data);
            if (of0) void'(q0.pop_front());
            if (in_valid && rdy0) q0.push_back(in_data);
        end
        #1;
    endtask

    initial begin
        tbl = '{
            '{1'b0,1'b0,1'b1,16'h0001,1'b1, 1'b1,1'b0,BUB,2'd0},
            '{1'b0,1'b0,1'b1,16'h0002,1'b1, 1'b1,1'b1,16'h0001,2'd1},
            '{1'b0,1'b0,1'b1,16'h0003,1'b1, 1'b1,1'b1,16'h0002,2'd1},
            '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b1,16'h0003,2'd1},
            '{1'b0,1'b0,1'b1,16'h000A,1'b0, 1'b1,1'b0,BUB,2'd0},
            '{1'b0,1'b0,1'b1,16'h000B,1'b0, 1'b1,1'b1,16'h000A,2'd1},
            '{1'b0,1'b0,1'b1,16'h000C,1'b0, 1'b0,1'b1,16'h000A,2'd2},
            '{1'b0,1'b0,1'b1,16'h000C,1'b1, 1'b0,1'b1,16'h000A,2'd2},
            '{1'b0,1'b0,1'b1,16'h000C,1'b1, 1'b1,1'b1,16'h000B,2'd1},
            '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b1,16'h000C,2'd1},
            '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,BUB,2'd0},
            '{1'b0,1'b0,1'b1,16'h000E,1'b0, 1'b1,1'b0,BUB,2'd0},
            '{1'b0,1'b0,1'b1,16'h000F,1'b0, 1'b1,1'b1,16'h000E,2'd1},
            '{1'b0,1'b1,1'b1,16'h000D,1'b0, 1'b0,1'b1,16'h000E,2'd2},
            '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,BUB,2'd0},
            '{1'b0,1'b0,1'b1,16'h0005,1'b0, 1'b1,1'b0,BUB,2'd0},
            '{1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b1,16'h0005,2'd1},
            '{1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b1,16'h0005,2'd1},
            '{1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b1,16'h0005,2'd1},
            '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b1,16'h0005,2'd1},
            '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,BUB,2'd0},
            '{1'b0,1'b0,1'b1,16'h0007,1'b0, 1'b1,1'b0,BUB,2'd0},
            '{1'b1,1'b1,1'b1,16'h0008,1'b0, 1'b0,1'b1,16'h0007,2'd1},
            '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,BUB,2'd0},
            '{1'b0,1'b0,1'b1,16'h0009,1'b0, 1'b1,1'b0,BUB,2'd0},
            '{1'b0,1'b1,1'b1,16'h0011,1'b0, 1'b1,1'b1,16'h0009,2'd1},
            '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,BUB,2'd0}
        };

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        #2;
        chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
        chk("rst_out_data", {16'd0, out_data1}, {16'd0, BUB});
        chk("rst_occupancy", {30'd0, occ1}, 32'd0);
        chk("rst_out_data0", {16'd0, out_data0}, {16'd0, BUB});
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].fr, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            @(negedge clk);
            chk($sformatf("t%0d_in_ready", i), {31'd0, in_ready1}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("t%0d_out_valid", i), {31'd0, out_valid1}, {31'd0, tbl[i].e_ov});
            chk($sformatf("t%0d_out_data", i), {16'd0, out_data1}, {16'd0, tbl[i].e_od});
            chk($sformatf("t%0d_occupancy", i), {30'd0, occ1}, {30'd0, tbl[i].e_occ});
            check_model(1'b0);
            advance();
        end

        // Single-entry variant: ready tracks out_ready with no clock in between
        drive(1'b0, 1'b0, 1'b1, 16'h0031, 1'b0);
        advance();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        #1 chk("s0_ready_low", {31'd0, in_ready0}, 32'd0);
        out_ready = 1'b1;
        #1 chk("s0_ready_high", {31'd0, in_ready0}, 32'd1);
        out_ready = 1'b0;

        // Asynchronous reset between edges with both stages holding a beat
        drive(1'b0, 1'b0, 1'b1, 16'h0021, 1'b0);
        advance();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid1}, 32'd0);
        chk("arst_out_data", {16'd0, out_data1}, {16'd0, BUB});
        chk("arst_occupancy", {30'd0, occ1}, 32'd0);
        chk("arst_out_valid0", {31'd0, out_valid0}, 32'd0);
        q1.delete();
        q0.delete();
        rst = 1'b0;
        advance();

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 6);
            @(negedge clk);
            check_model(1'b1);
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
